dmem_responder: RTL and testbench
=================================

// Module: dmem_responder
// PURPOSE
//  Responder end of the core's data-memory load/store interface. Accepts one request at a time
//  (rd_en/wr_en/addr/wdata/size) over a valid/ready handshake and drives a word-wide, byte-enabled SRAM.
//  Returns aligned, sign/zero-extended load data, or an error response, over a one-cycle resp_valid pulse.
//  Sits between the MW stage and on-chip data RAM; the core stalls while req_ready=0.
// PARAMETERS
//  DEPTH_WORDS  1024  number of 32-bit words in backing RAM (power of 2)
//  READ_LAT     1     SRAM read latency in cycles, legal range 1..3
// PORTS
//  clk         in   1   clock, all state updates on rising edge
//  reset       in   1   synchronous, active-high reset
//  req_valid   in   1   request present on rd_en/wr_en/addr/wdata/size
//  req_ready   out  1   responder can accept; handshake = req_valid & req_ready
//  rd_en       in   1   load request
//  wr_en       in   1   store request
//  addr        in   32  byte address
//  wdata       in   32  store data, LSB-justified
//  size        in   3   funct3 encoding: 000 B, 001 H, 010 W, 100 BU, 101 HU
//  resp_valid  out  1   one-cycle response pulse
//  rdata       out  32  load result (0 for stores and errors)
//  resp_err    out  1   qualifies resp_valid: request rejected
// BEHAVIOUR
//  - Reset: state IDLE, req_ready=0 during reset cycle, resp_valid=0, rdata=0, resp_err=0; RAM not cleared.
//    Reset mid-operation abandons request: no response; a store not yet committed is dropped.
//  - FSM: IDLE -> WRITE | READ | ERR on handshake; WRITE -> IDLE; READ (READ_LAT cycles) -> RESP -> IDLE;
//    ERR -> IDLE. req_ready=1 only in IDLE; requests offered elsewhere are not accepted (master holds).
//  - Request (addr, wdata, size, op) registered at handshake; inputs ignored afterwards.
//  - Error checks at handshake, in priority: rd_en==wr_en; size not in legal set
//    (stores: 000/001/010 only); H/HU with addr[0]=1; W with addr[1:0]!=0; addr[31:2]>=DEPTH_WORDS.
//    Any -> ERR: no RAM access, resp_valid=1, resp_err=1, rdata=0 one cycle after handshake.
//  - Store: byte enables B: 1<<addr[1:0], H: 2'b11<<{addr[1],1'b0}, W: 4'hF; write data lane-replicated.
//    RAM written at the edge ending WRITE; resp_valid=1, rdata=0 in cycle handshake+1.
//    A load accepted afterwards sees the new data.
//  - Load: RAM read issued from registered address; resp_valid in cycle handshake+READ_LAT+1.
//    Byte/half selected by addr[1:0]; B/H sign-extend, BU/HU zero-extend, W passes through.
//  - Outputs registered; rdata/resp_err are 0 whenever resp_valid=0.
//  - Throughput: store/error 1 req per 2 cycles; load 1 per READ_LAT+2 cycles.
// STRUCTURE
//  - header_pkg: mem_size_t enum (MEM_B, MEM_H, MEM_W, MEM_BU, MEM_HU) and dmem_state_t
//    (IDLE, WRITE, READ, RESP, ERR).
//  - Sub-module sram_sp_be: single-port DEPTH_WORDS x 32 RAM, 4 byte enables, READ_LAT-deep read pipeline.
//  - dmem_responder holds FSM, request register, error check, byte-enable gen and load alignment/extension.
// TESTING
//  1. SW 0xDEADBEEF @0x10, then LW @0x10 (READ_LAT=1) -> store resp at hs+1 err=0;
//     load resp at hs+2, rdata=0xDEADBEEF.
//  2. SB wdata=0x80 @0x13 -> LB @0x13=0xFFFFFF80; LBU @0x13=0x00000080; LW @0x10=0x80ADBEEF.
//  3. LH @0x11, SW @0x12, rd_en=wr_en=1 @0x0 -> each resp_err=1, rdata=0 at hs+1;
//     following LW @0x10 still 0x80ADBEEF.
//  4. LW @ 4*DEPTH_WORDS (0x1000) -> resp_err=1; SH 0xBEEF @0xFFE -> ok;
//     LHU @0xFFE=0x0000BEEF, LH=0xFFFFBEEF.
//  5. READ_LAT=3: LW accepted cycle t -> req_ready=0 t+1..t+4; resp_valid only at t+4;
//     req_valid held throughout not accepted until t+5.
//  6. Assert reset during READ or WRITE -> no resp_valid; aborted SW leaves word unchanged;
//     req_ready=1 first cycle after reset drops.

Source files
------------

// File: rtl/dmem_responder_pkg.sv
// Shared types and helpers for the data-memory responder: access-size encoding,
// FSM states and store byte-enable generation.
package dmem_responder_pkg;

  typedef enum logic [2:0] {
    MEM_B  = 3'b000,
    MEM_H  = 3'b001,
    MEM_W  = 3'b010,
    MEM_BU = 3'b100,
    MEM_HU = 3'b101
  } mem_size_t;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    READ,
    RESP,
    ERR
  } dmem_state_t;

  function automatic logic [3:0] byte_en(input logic [2:0] sz, input logic [1:0] a);
    logic [3:0] be;
    case (sz)
      MEM_B:   be = 4'b0001 << a;
      MEM_H:   be = a[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/dmem_responder_sram_sp_be.sv
// Single-port word RAM with per-byte write enables and a READ_LAT-deep read pipeline.
module sram_sp_be #(
  parameter int DEPTH_WORDS = 1024,
  parameter int READ_LAT    = 1,
  localparam int AW         = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic          re_i,
  input  logic [3:0]    be_i,
  input  logic [AW-1:0] addr_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_q  [DEPTH_WORDS];
  logic [31:0] pipe_q [READ_LAT];

  always_ff @(posedge clk) begin
    if (we_i) begin
      for (int b = 0; b < 4; b++) begin
        if (be_i[b]) mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
    if (re_i) pipe_q[0] <= mem_q[addr_i];
    for (int i = 1; i < READ_LAT; i++) pipe_q[i] <= pipe_q[i-1];
  end

  assign rdata_o = pipe_q[READ_LAT-1];

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one load/store at a time, checks it, drives the
// byte-enabled SRAM and returns aligned/extended load data or an error pulse.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int READ_LAT    = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        rd_en,
  input  logic        wr_en,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [2:0]  size,
  output logic        resp_valid,
  output logic [31:0] rdata,
  output logic        resp_err
);

  localparam int          AW       = $clog2(DEPTH_WORDS);
  localparam logic [31:0] DEPTH_32 = 32'(DEPTH_WORDS);
  localparam logic [1:0]  LAT_LAST = 2'(READ_LAT - 1);

  dmem_state_t state_q, state_d;
  logic [1:0]    lat_q, lat_d;
  logic          resp_valid_q, resp_valid_d;
  logic          resp_err_q, resp_err_d;
  logic [AW+1:0] addr_q;
  logic [31:0]   wdata_q;
  logic [2:0]    size_q;
  logic          hs, req_bad, ram_we, ram_re;
  logic [31:0]   ram_wdata, ram_rdata;

  function automatic logic req_error(input logic rd, input logic wr,
                                     input logic [31:0] a, input logic [2:0] sz);
    logic legal_ld, legal_st;
    legal_st = (sz == MEM_B) || (sz == MEM_H) || (sz == MEM_W);
    legal_ld = legal_st || (sz == MEM_BU) || (sz == MEM_HU);
    if (rd == wr)                                  return 1'b1;
    if ((wr && !legal_st) || (rd && !legal_ld))    return 1'b1;
    if (((sz == MEM_H) || (sz == MEM_HU)) && a[0]) return 1'b1;
    if ((sz == MEM_W) && (a[1:0] != 2'b00))        return 1'b1;
    return ({2'b00, a[31:2]} >= DEPTH_32);
  endfunction

  function automatic logic [31:0] load_align(input logic [31:0] w, input logic [2:0] sz,
                                             input logic [1:0] a);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{a, 3'b000} +: 8];
    h = a[1] ? w[31:16] : w[15:0];
    case (sz)
      MEM_B:   return {{24{b[7]}}, b};
      MEM_BU:  return {24'h0, b};
      MEM_H:   return {{16{h[15]}}, h};
      MEM_HU:  return {16'h0, h};
      default: return w;
    endcase
  endfunction

  assign req_ready = (state_q == IDLE) && !reset;
  assign hs        = req_valid && req_ready;
  assign req_bad   = req_error(rd_en, wr_en, addr, size);

  always_comb begin
    state_d      = state_q;
    lat_d        = lat_q;
    resp_valid_d = 1'b0;
    resp_err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (hs) begin
          lat_d = 2'd0;
          if (req_bad) begin
            state_d      = ERR;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
          end else if (wr_en) begin
            state_d      = WRITE;
            resp_valid_d = 1'b1;
          end else begin
            state_d = READ;
          end
        end
      end
      READ: begin
        if (lat_q == LAT_LAST) begin
          state_d      = RESP;
          resp_valid_d = 1'b1;
        end else begin
          lat_d = lat_q + 2'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      lat_q        <= 2'd0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      lat_q        <= lat_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
    end
  end

  // Request is captured only at the handshake; inputs are don't-care afterwards
  always_ff @(posedge clk) begin
    if (hs) begin
      addr_q  <= addr[AW+1:0];
      wdata_q <= wdata;
      size_q  <= size;
    end
  end

  always_comb begin
    case (size_q)
      MEM_B:   ram_wdata = {4{wdata_q[7:0]}};
      MEM_H:   ram_wdata = {2{wdata_q[15:0]}};
      default: ram_wdata = wdata_q;
    endcase
  end

  // A reset coinciding with the commit edge drops the store
  assign ram_we = (state_q == WRITE) && !reset;
  assign ram_re = (state_q == READ);

  sram_sp_be #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .READ_LAT   (READ_LAT)
  ) u_sram (
    .clk    (clk),
    .we_i   (ram_we),
    .re_i   (ram_re),
    .be_i   (byte_en(size_q, addr_q[1:0])),
    .addr_i (addr_q[AW+1:2]),
    .wdata_i(ram_wdata),
    .rdata_o(ram_rdata)
  );

  assign resp_valid = resp_valid_q && !reset;
  assign resp_err   = resp_valid && resp_err_q;
  assign rdata      = (resp_valid && (state_q == RESP)) ?
                      load_align(ram_rdata, size_q, addr_q[1:0]) : 32'h0;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: directed loads/stores on READ_LAT=1 and 3 instances.
module tb_dmem_responder;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;
  exp_t q1[$];
  exp_t q3[$];
  exp_t e1, e3;

  logic        rst1, v1, rd1, wr1, rdy1, rv1, err1;
  logic [31:0] a1, wd1, rdat1;
  logic [2:0]  sz1;
  logic        rst3, v3, rd3, wr3, rdy3, rv3, err3;
  logic [31:0] a3, wd3, rdat3;
  logic [2:0]  sz3;

  dmem_responder #(.DEPTH_WORDS(1024), .READ_LAT(1)) dut1 (
    .clk(clk), .reset(rst1), .req_valid(v1), .req_ready(rdy1), .rd_en(rd1), .wr_en(wr1),
    .addr(a1), .wdata(wd1), .size(sz1), .resp_valid(rv1), .rdata(rdat1), .resp_err(err1)
  );

  dmem_responder #(.DEPTH_WORDS(1024), .READ_LAT(3)) dut3 (
    .clk(clk), .reset(rst3), .req_valid(v3), .req_ready(rdy3), .rd_en(rd3), .wr_en(wr3),
    .addr(a3), .wdata(wd3), .size(sz3), .resp_valid(rv3), .rdata(rdat3), .resp_err(err3)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (rv1) begin
        if (q1.size() == 0) begin
          checks++; errors++;
          $display("FAIL lat1_unexpected_resp actual rdata=%h err=%b expected no response", rdat1, err1);
        end else begin
          e1 = q1.pop_front();
          chk("lat1_resp_cycle", 32'(cyc), 32'(e1.cyc));
          chk("lat1_rdata", rdat1, e1.rdata);
          chk("lat1_err", {31'h0, err1}, {31'h0, e1.err});
        end
      end else begin
        chk("lat1_idle_zero", rdat1 | {31'h0, err1}, 32'h0);
      end
      if (rv3) begin
        if (q3.size() == 0) begin
          checks++; errors++;
          $display("FAIL lat3_unexpected_resp actual rdata=%h err=%b expected no response", rdat3, err3);
        end else begin
          e3 = q3.pop_front();
          chk("lat3_resp_cycle", 32'(cyc), 32'(e3.cyc));
          chk("lat3_rdata", rdat3, e3.rdata);
          chk("lat3_err", {31'h0, err3}, {31'h0, e3.err});
        end
      end
    end
  end

  task automatic issue1(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] wd,
                        input logic [2:0] sz, input logic [31:0] er, input logic ee, input bit abort);
    int n;
    int lat;
    @(posedge clk); #1;
    v1 = 1'b1; rd1 = rd; wr1 = wr; a1 = a; wd1 = wd; sz1 = sz;
    n = 0;
    @(negedge clk);
    while (!rdy1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!rdy1) begin
      chk("lat1_handshake_timeout", {31'h0, rdy1}, 32'h1);
      v1 = 1'b0;
      return;
    end
    lat = (rd && !wr && !ee) ? 2 : 1;
    if (!abort) q1.push_back('{rdata: er, err: ee, cyc: cyc + lat});
    @(posedge clk); #1;
    v1 = 1'b0; rd1 = 1'b0; wr1 = 1'b0;
    if (abort) begin
      rst1 = 1'b1;
      @(negedge clk);
      chk("abort_ready_in_reset", {31'h0, rdy1}, 32'h0);
      @(posedge clk); #1;
      rst1 = 1'b0;
      @(negedge clk);
      chk("abort_ready_after_reset", {31'h0, rdy1}, 32'h1);
    end
  endtask

  task automatic issue3_store(input logic [31:0] a, input logic [31:0] wd);
    int n;
    @(posedge clk); #1;
    v3 = 1'b1; rd3 = 1'b0; wr3 = 1'b1; a3 = a; wd3 = wd; sz3 = 3'b010;
    n = 0;
    @(negedge clk);
    while (!rdy3 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("lat3_store_handshake", {31'h0, rdy3}, 32'h1);
    q3.push_back('{rdata: 32'h0, err: 1'b0, cyc: cyc + 1});
    @(posedge clk); #1;
    v3 = 1'b0; wr3 = 1'b0;
  endtask

  initial begin
    int t;
    rst1 = 1'b1; v1 = 1'b0; rd1 = 1'b0; wr1 = 1'b0; a1 = '0; wd1 = '0; sz1 = '0;
    rst3 = 1'b1; v3 = 1'b0; rd3 = 1'b0; wr3 = 1'b0; a3 = '0; wd3 = '0; sz3 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_ready", {31'h0, rdy1}, 32'h0);
    chk("reset_resp_valid", {31'h0, rv1}, 32'h0);
    chk("reset_rdata", rdat1, 32'h0);
    chk("reset_err", {31'h0, err1}, 32'h0);
    chk("reset_ready_lat3", {31'h0, rdy3}, 32'h0);
    @(posedge clk); #1;
    rst1 = 1'b0; rst3 = 1'b0; mon_en = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", {31'h0, rdy1}, 32'h1);

    // store/load round trip, byte and half extension
    issue1(0, 1, 32'h10,  32'hDEADBEEF, 3'b010, 32'h0,        0, 0);
    issue1(1, 0, 32'h10,  32'h0,        3'b010, 32'hDEADBEEF, 0, 0);
    issue1(0, 1, 32'h13,  32'h00000080, 3'b000, 32'h0,        0, 0);
    issue1(1, 0, 32'h13,  32'h0,        3'b000, 32'hFFFFFF80, 0, 0);
    issue1(1, 0, 32'h13,  32'h0,        3'b100, 32'h00000080, 0, 0);
    issue1(1, 0, 32'h10,  32'h0,        3'b010, 32'h80ADBEEF, 0, 0);
    issue1(1, 0, 32'h11,  32'h0,        3'b000, 32'hFFFFFFBE, 0, 0);
    issue1(1, 0, 32'h10,  32'h0,        3'b101, 32'h0000BEEF, 0, 0);
    issue1(1, 0, 32'h12,  32'h0,        3'b001, 32'hFFFF80AD, 0, 0);
    // error responses
    issue1(1, 0, 32'h11,  32'h0,        3'b001, 32'h0,        1, 0);
    issue1(0, 1, 32'h12,  32'h55,       3'b010, 32'h0,        1, 0);
    issue1(1, 1, 32'h0,   32'h0,        3'b010, 32'h0,        1, 0);
    issue1(1, 0, 32'h8,   32'h0,        3'b011, 32'h0,        1, 0);
    issue1(0, 1, 32'h8,   32'h1,        3'b100, 32'h0,        1, 0);
    issue1(0, 0, 32'h10,  32'h0,        3'b010, 32'h0,        1, 0);
    issue1(1, 0, 32'h10,  32'h0,        3'b010, 32'h80ADBEEF, 0, 0);
    // address range edge
    issue1(1, 0, 32'h1000, 32'h0,       3'b010, 32'h0,        1, 0);
    issue1(0, 1, 32'hFFE, 32'h0000BEEF, 3'b001, 32'h0,        0, 0);
    issue1(1, 0, 32'hFFE, 32'h0,        3'b101, 32'h0000BEEF, 0, 0);
    issue1(1, 0, 32'hFFE, 32'h0,        3'b001, 32'hFFFFBEEF, 0, 0);
    // reset during READ and during WRITE
    issue1(1, 0, 32'h10,  32'h0,        3'b010, 32'h0,        0, 1);
    issue1(0, 1, 32'h10,  32'h11111111, 3'b010, 32'h0,        0, 1);
    issue1(1, 0, 32'h10,  32'h0,        3'b010, 32'h80ADBEEF, 0, 0);

    // READ_LAT=3: request held valid across the whole load
    issue3_store(32'h20, 32'h12345678);
    @(posedge clk); #1;
    v3 = 1'b1; rd3 = 1'b1; wr3 = 1'b0; a3 = 32'h20; sz3 = 3'b010;
    @(negedge clk);
    t = 0;
    while (!rdy3 && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("lat3_load_handshake", {31'h0, rdy3}, 32'h1);
    t = cyc;
    q3.push_back('{rdata: 32'h12345678, err: 1'b0, cyc: t + 4});
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      chk("lat3_ready_low", {31'h0, rdy3}, 32'h0);
    end
    @(negedge clk);
    chk("lat3_reaccept_cycle", 32'(cyc), 32'(t + 5));
    chk("lat3_reaccept_ready", {31'h0, rdy3}, 32'h1);
    q3.push_back('{rdata: 32'h12345678, err: 1'b0, cyc: cyc + 4});
    @(posedge clk); #1;
    v3 = 1'b0; rd3 = 1'b0;

    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("lat1_queue_drained", 32'(q1.size()), 32'h0);
    chk("lat3_queue_drained", 32'(q3.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
